// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, next-PC select codes and datapath width.
// Imported by instruction_fetch and next_pc_sel.
package cpu_pkg;

    localparam int INSTR_WIDTH = 32;

    // Fetch FSM state encoding, also driven out on the debug state port.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    // Branch target: word offset scaled to bytes.
    // Bits shifted out of the top of the offset are discarded.
    function automatic logic [INSTR_WIDTH-1:0] branch_target(
        input logic [INSTR_WIDTH-1:0] pc_plus4,
        input logic [INSTR_WIDTH-1:0] word_offset
    );
        return pc_plus4 + (word_offset << 2);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux.
// Selects PC+4, branch, jump or register target from the fetch datapath.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] pc_plus4,
    input  logic [25:0]            jump_index,
    input  logic [1:0]             pc_src,
    input  logic [INSTR_WIDTH-1:0] imm,
    input  logic [INSTR_WIDTH-1:0] reg_target,
    output logic [INSTR_WIDTH-1:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        unique case (pc_src)
            PC_SRC_PLUS4:  next_pc = pc_plus4;
            PC_SRC_BRANCH: next_pc = branch_target(pc_plus4, imm);
            // Jump stays within the 256 MB region of the following instruction.
            PC_SRC_JUMP:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
            PC_SRC_REG:    next_pc = reg_target;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: runs the memory request/acknowledge handshake with a bounded
// wait timeout, holds the PC and IR registers, and drives the next-PC select.
//
// Memory handshake: Mem_req_out rises in REQ and stays high through WAIT until a cycle
// in which Mem_ack_in=1. Mem_data_in is captured in that same cycle. No request is
// issued from IDLE, DONE or FAULT.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                   CLK_in,
    input  logic                   Reset_n,
    input  logic                   Fetch_en,
    input  logic [INSTR_WIDTH-1:0] PC_in,
    input  logic [1:0]             PCSrc_in,
    input  logic [INSTR_WIDTH-1:0] Imm_in,
    input  logic [INSTR_WIDTH-1:0] RegTarget_in,
    input  logic                   Mem_ack_in,
    input  logic [INSTR_WIDTH-1:0] Mem_data_in,
    output logic                   Mem_req_out,
    output logic [INSTR_WIDTH-1:0] Mem_addr_out,
    output logic [INSTR_WIDTH-1:0] Instr_out,
    output logic [INSTR_WIDTH-1:0] PCPlus4_out,
    output logic [INSTR_WIDTH-1:0] NextPC_out,
    output logic                   Busy_out,
    output logic                   Done_out,
    output logic                   Fault_out,
    output logic [2:0]             State_out
);

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [INSTR_WIDTH-1:0] pc_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic [7:0]             wait_cnt;
    logic                   pc_aligned;
    logic                   wait_expired;

    assign pc_aligned = (PC_in[1:0] == 2'b00);
    // The counter holds the number of completed WAIT cycles.
    // The MAX_WAIT-th WAIT cycle without an acknowledge is therefore the last one.
    assign wait_expired = (wait_cnt == 8'(MAX_WAIT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Fetch_en) begin
                    state_nxt = pc_aligned ? ST_REQ : ST_FAULT;
                end
            end
            ST_REQ: begin
                state_nxt = Mem_ack_in ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // An acknowledge arriving in the timeout cycle still completes the fetch.
                if (Mem_ack_in) begin
                    state_nxt = ST_DONE;
                end else if (wait_expired) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_in or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (Fetch_en && pc_aligned) begin
                        pc_q <= PC_in;
                    end
                end
                ST_REQ: begin
                    if (Mem_ack_in) begin
                        ir_q <= Mem_data_in;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (Mem_ack_in) begin
                        ir_q <= Mem_data_in;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Mem_req_out  = (state == ST_REQ) || (state == ST_WAIT);
    assign Busy_out     = (state == ST_REQ) || (state == ST_WAIT);
    assign Done_out     = (state == ST_DONE);
    assign Fault_out    = (state == ST_FAULT);
    assign State_out    = state;
    assign Mem_addr_out = pc_q;
    assign Instr_out    = ir_q;
    assign PCPlus4_out  = pc_q + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4   (PCPlus4_out),
        .jump_index (ir_q[25:0]),
        .pc_src     (PCSrc_in),
        .imm        (Imm_in),
        .reg_target (RegTarget_in),
        .next_pc    (NextPC_out)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: table of fetch vectors with next-PC expectations,
// plus hand-written timeout, misalignment and reset sequences.
module tb_instruction_fetch;
    import cpu_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int NO_ACK   = 1000;

    logic        CLK_in = 1'b0;
    logic        Reset_n;
    logic        Fetch_en;
    logic [31:0] PC_in;
    logic [1:0]  PCSrc_in;
    logic [31:0] Imm_in;
    logic [31:0] RegTarget_in;
    logic        Mem_ack_in;
    logic [31:0] Mem_data_in;
    logic        Mem_req_out;
    logic [31:0] Mem_addr_out;
    logic [31:0] Instr_out;
    logic [31:0] PCPlus4_out;
    logic [31:0] NextPC_out;
    logic        Busy_out;
    logic        Done_out;
    logic        Fault_out;
    logic [2:0]  State_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rtgt;
        int          wait_n;
        logic [31:0] exp_plus4;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[8];

    // clock / reset
    always #5 CLK_in = ~CLK_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    instruction_fetch #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK_in       (CLK_in),
        .Reset_n      (Reset_n),
        .Fetch_en     (Fetch_en),
        .PC_in        (PC_in),
        .PCSrc_in     (PCSrc_in),
        .Imm_in       (Imm_in),
        .RegTarget_in (RegTarget_in),
        .Mem_ack_in   (Mem_ack_in),
        .Mem_data_in  (Mem_data_in),
        .Mem_req_out  (Mem_req_out),
        .Mem_addr_out (Mem_addr_out),
        .Instr_out    (Instr_out),
        .PCPlus4_out  (PCPlus4_out),
        .NextPC_out   (NextPC_out),
        .Busy_out     (Busy_out),
        .Done_out     (Done_out),
        .Fault_out    (Fault_out),
        .State_out    (State_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expects PCSrc_in = 00 so that NextPC_out equals the reset PC + 4.
    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_req"}, {31'b0, Mem_req_out}, 32'd0);
        check({tag, "_busy"},    {31'b0, Busy_out},    32'd0);
        check({tag, "_done"},    {31'b0, Done_out},    32'd0);
        check({tag, "_fault"},   {31'b0, Fault_out},   32'd0);
        check({tag, "_addr"},    Mem_addr_out,         32'd0);
        check({tag, "_instr"},   Instr_out,            32'd0);
        check({tag, "_plus4"},   PCPlus4_out,          32'd4);
        check({tag, "_next"},    NextPC_out,           32'd4);
        check({tag, "_state"},   {29'b0, State_out},   {29'b0, ST_IDLE});
    endtask

    // driver: one fetch from IDLE; memory acknowledges once wait_n WAIT cycles have been entered.
    // Fetch_en is re-asserted with a different address while busy; it must be ignored.
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data, input int wait_n,
                             output int busy_n, output int lat, output bit addr_ok);
        busy_n  = 0;
        lat     = 0;
        addr_ok = 1'b1;
        @(negedge CLK_in);
        Fetch_en    = 1'b1;
        PC_in       = pc;
        Mem_ack_in  = 1'b0;
        Mem_data_in = data;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK_in);
            lat++;
            if (Done_out || Fault_out) break;
            if (Busy_out) begin
                busy_n++;
                if (Mem_addr_out !== pc || Mem_req_out !== 1'b1) addr_ok = 1'b0;
            end
            Fetch_en   = (busy_n >= 2);
            PC_in      = ~pc;
            Mem_ack_in = (busy_n == wait_n + 1);
        end
        Fetch_en   = 1'b0;
        Mem_ack_in = 1'b0;
        PC_in      = pc;
        // scoreboard: compare the captured instruction when the fetch completes
        if (Done_out) begin
            if (exp_q.size() != 0) check("instr", Instr_out, exp_q.pop_front());
            else check("spurious_done", {31'b0, Done_out}, 32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK_in);
        PCSrc_in = PC_SRC_PLUS4;
        Reset_n  = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge CLK_in);
        Reset_n = 1'b1;
    endtask

    initial begin
        int busy_n, lat;
        bit addr_ok;
        logic [31:0] held_instr;

        Reset_n = 1'b0; Fetch_en = 1'b0; PC_in = '0; PCSrc_in = PC_SRC_PLUS4;
        Imm_in = '0; RegTarget_in = '0; Mem_ack_in = 1'b0; Mem_data_in = '0;

        vecs[0] = '{32'h0040_0000, 32'h8C22_0004, PC_SRC_PLUS4,  32'h0,         32'h0,         0, 32'h0040_0004, 32'h0040_0004};
        vecs[1] = '{32'h0040_0000, 32'h0810_0003, PC_SRC_JUMP,   32'h0,         32'h0,         3, 32'h0040_0004, 32'h0040_000C};
        vecs[2] = '{32'h0040_0010, 32'h1000_FFFE, PC_SRC_BRANCH, 32'hFFFF_FFFE, 32'h0,         1, 32'h0040_0014, 32'h0040_000C};
        vecs[3] = '{32'hFFFF_FFFC, 32'h1234_5678, PC_SRC_PLUS4,  32'h0,         32'h0,         0, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'hF000_0000, 32'h0BFF_FFFF, PC_SRC_JUMP,   32'h0,         32'h0,         2, 32'hF000_0004, 32'hFFFF_FFFC};
        vecs[5] = '{32'h0000_1000, 32'hDEAD_BEEF, PC_SRC_REG,    32'h0,         32'hCAFE_BABF, 0, 32'h0000_1004, 32'hCAFE_BABF};
        vecs[6] = '{32'h7FFF_FFF0, 32'h0000_0000, PC_SRC_BRANCH, 32'h4000_0001, 32'h0,         5, 32'h7FFF_FFF4, 32'h7FFF_FFF8};
        vecs[7] = '{32'h0000_0100, 32'hA5A5_5A5A, PC_SRC_BRANCH, 32'h0000_0010, 32'h0,         0, 32'h0000_0104, 32'h0000_0144};

        #12;
        check_reset_vals("por");
        @(negedge CLK_in);
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            PCSrc_in     = vecs[i].src;
            Imm_in       = vecs[i].imm;
            RegTarget_in = vecs[i].rtgt;
            exp_q.push_back(vecs[i].instr);
            run_fetch(vecs[i].pc, vecs[i].instr, vecs[i].wait_n, busy_n, lat, addr_ok);
            check("done",       {31'b0, Done_out}, 32'd1);
            check("busy_cycles", busy_n,           vecs[i].wait_n + 1);
            check("latency",     lat,              vecs[i].wait_n + 2);
            check("addr_req",    {31'b0, addr_ok}, 32'd1);
            check("plus4",       PCPlus4_out,      vecs[i].exp_plus4);
            check("next_pc",     NextPC_out,       vecs[i].exp_next);
            @(negedge CLK_in);
            check("done_pulse",  {31'b0, Done_out}, 32'd0);
            check("idle_after",  {29'b0, State_out}, {29'b0, ST_IDLE});
            @(negedge CLK_in);
            check("ir_hold",     Instr_out,        vecs[i].instr);
            check("next_hold",   NextPC_out,       vecs[i].exp_next);
        end

        // timeout: no acknowledge ever, FAULT after MAX_WAIT WAIT cycles, sticky
        PCSrc_in = PC_SRC_PLUS4;
        run_fetch(32'h0040_0100, 32'h0, NO_ACK, busy_n, lat, addr_ok);
        check("to_fault",      {31'b0, Fault_out},   32'd1);
        check("to_wait_cnt",   busy_n - 1,           MAX_WAIT);
        check("to_mem_req",    {31'b0, Mem_req_out}, 32'd0);
        check("to_busy",       {31'b0, Busy_out},    32'd0);
        for (int k = 0; k < 3; k++) begin
            Fetch_en = 1'b1; PC_in = 32'h0040_0200; Mem_ack_in = 1'b1;
            @(negedge CLK_in);
            check("to_sticky",     {29'b0, State_out},   {29'b0, ST_FAULT});
            check("to_sticky_req", {31'b0, Mem_req_out}, 32'd0);
        end
        Fetch_en = 1'b0; Mem_ack_in = 1'b0;
        apply_reset();

        // acknowledge in the last allowed WAIT cycle wins over the timeout
        exp_q.push_back(32'h2108_0001);
        run_fetch(32'h0040_0300, 32'h2108_0001, MAX_WAIT, busy_n, lat, addr_ok);
        check("ack15_done",  {31'b0, Done_out},  32'd1);
        check("ack15_fault", {31'b0, Fault_out}, 32'd0);
        check("ack15_lat",   lat,                MAX_WAIT + 2);

        // misaligned PC goes straight to FAULT without a request or PC latch
        run_fetch(32'h0040_0002, 32'h0, 0, busy_n, lat, addr_ok);
        check("mis_fault", {31'b0, Fault_out},   32'd1);
        check("mis_busy",  busy_n,               0);
        check("mis_req",   {31'b0, Mem_req_out}, 32'd0);
        check("mis_addr",  Mem_addr_out,         32'h0040_0300);
        apply_reset();

        // asynchronous reset in the middle of WAIT
        @(negedge CLK_in);
        Fetch_en = 1'b1; PC_in = 32'h0040_0400; Mem_ack_in = 1'b0;
        @(negedge CLK_in);
        Fetch_en = 1'b0;
        repeat (3) @(negedge CLK_in);
        check("mid_state", {29'b0, State_out},   {29'b0, ST_WAIT});
        check("mid_req",   {31'b0, Mem_req_out}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge CLK_in);
        Reset_n = 1'b1;

        // recovery after reset
        held_instr = 32'h0123_4567;
        exp_q.push_back(held_instr);
        run_fetch(32'h0000_0040, held_instr, 1, busy_n, lat, addr_ok);
        check("rec_done",  {31'b0, Done_out}, 32'd1);
        check("rec_plus4", PCPlus4_out,       32'h0000_0044);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
